hazard_unit_param: RTL and testbench
====================================

Name: hazard_unit_param

Overview:
Parametrised hazard and forwarding controller for the pipelined ARM core (F/D/E/M/W). It generalises the hazard unit in four ways: N read ports with per-port forwarding; multi-cycle load-use stalls; an N-phase multi-cycle op sequencer that replaces the single WriteMultLo flop; and a registered stall-cause status. It sits beside the datapath and drives all stall, flush and forward selects.

Parameters:
NREAD, 2, number of E-stage register read ports needing forwarding (1..4)
LOAD_USE_CYCLES, 1, D-stage stall cycles per load-use hazard (1..4)
MULT_PHASES, 2, D-stage phases of a multi-cycle op (2..8)
PW, $clog2(MULT_PHASES), width of phase index

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
Match_E_M  in  NREAD  port i E-source equals M dest
Match_E_W  in  NREAD  port i E-source equals W dest
Match_D_E  in  1  any D source equals E dest
RegWriteM, RegWriteW  in  1 each  M/W write enables
MemtoRegE  in  1  E instr is a load
BranchTakenE  in  1  branch resolved taken in E
PCWrPendingF  in  1  PC write in flight
PCSrcW  in  1  PC written in W
dstall, istall  in  1 each  data/instruction memory stall
uOpStallD  in  1  micro-op sequencer holds D
MultReqD  in  1  multi-cycle op in D
ForwardE  out  2*NREAD  per-port select; bits [2i+1:2i]: 10=M, 01=W, 00=regfile
StallF, StallD, StallE, StallM, StallW  out  1 each
FlushD, FlushE, FlushW  out  1 each
MultPhaseD  out  PW  current phase of multi-cycle op
MultLastD  out  1  final phase is in D
StallCause  out  4  registered {mult, uop, ldr, mem}

Behaviour:
- Forwarding, combinational per port i: Match_E_M[i]&RegWriteM -> 10; else Match_E_W[i]&RegWriteW -> 01; else 00. M has priority over W.
- memStall = dstall|istall. When memStall=1, the load and mult counters hold their value.
- Load-use: ldrHit = Match_D_E & MemtoRegE. ldrCnt (2b) reset 0. When ldrCnt==0 and ldrHit and !memStall: ldrCnt <= LOAD_USE_CYCLES-1. When ldrCnt>0 and !memStall: ldrCnt decrements. ldrStall = (ldrCnt==0 & ldrHit) | ldrCnt!=0. With LOAD_USE_CYCLES=1, ldrCnt stays 0 and the stall is purely combinational.
- Mult sequencer, states IDLE/BUSY, phase counter ph reset 0:
  - IDLE: when MultReqD & !memStall & !ldrStall: ph <= 1, go to BUSY.
  - BUSY: when !memStall & !ldrStall, ph increments. When ph==MULT_PHASES-1 and it advances: ph <= 0, go to IDLE.
  - MultPhaseD = ph. MultLastD = MultReqD & (ph==MULT_PHASES-1).
  - multStall = MultReqD & !MultLastD.
  - If FlushD or FlushE is asserted while BUSY: next state IDLE, ph <= 0. Abort takes priority over advance.
- Stall and flush equations:
  - StallD = ldrStall|memStall|uOpStallD|multStall
  - StallF = StallD|PCWrPendingF
  - StallE = StallM = memStall; StallW = istall; FlushW = memStall
  - FlushE = ldrStall|BranchTakenE
  - FlushD = PCWrPendingF|PCSrcW|BranchTakenE|istall
- StallCause is a register updated every cycle with {multStall, uOpStallD, ldrStall, memStall}. Reset value 0.
- Reset: ldrCnt=0, state=IDLE, ph=0, StallCause=0. Combinational outputs follow their inputs during reset. Reset mid-sequence aborts at the next edge; the first post-reset cycle behaves as IDLE.
- Simultaneous events:
  - Load-use and MultReqD together: the load stall is served first and the sequencer waits in IDLE.
  - A branch in the same cycle as the final mult phase: the flush wins and the sequencer returns to IDLE.

Test Plan:
- NREAD=2; Match_E_M=01, Match_E_W=11, RegWriteM=RegWriteW=1 -> ForwardE=4'b0110. Same inputs with RegWriteM=0 -> 4'b0101.
- LOAD_USE_CYCLES=3; single-cycle ldrHit pulse -> StallD=StallF=FlushE=1 for exactly 3 cycles. A dstall inserted in cycle 2 -> the stall stretches to 4 cycles.
- MULT_PHASES=4; MultReqD held -> MultPhaseD 0,1,2,3, StallD=1,1,1,0, MultLastD=0,0,0,1, then back to IDLE.
- MULT_PHASES=4; BranchTakenE at ph=2 -> FlushD=1, next-cycle ph=0, state IDLE.
- istall=1 with PCSrcW=1 -> StallF/D/E/M/W=1, FlushD=1, FlushW=1, counters frozen. StallCause=4'b0001 on the following cycle.
- reset asserted at ph=2 -> next cycle ph=0 and StallCause=0. After reset deasserts, MultReqD restarts at phase 0.

Source files
------------

// File: rtl/hazard_unit_param_if.sv
// Datapath <-> hazard controller bundle: hazard detection inputs and stall/flush/forward controls.
// The datapath drives through master; the hazard unit attaches as slave.
interface hazard_unit_param_if #(
    parameter int unsigned NREAD = 2,
    parameter int unsigned PW    = 1
);
    logic [NREAD-1:0]   Match_E_M;
    logic [NREAD-1:0]   Match_E_W;
    logic               Match_D_E;
    logic               RegWriteM;
    logic               RegWriteW;
    logic               MemtoRegE;
    logic               BranchTakenE;
    logic               PCWrPendingF;
    logic               PCSrcW;
    logic               dstall;
    logic               istall;
    logic               uOpStallD;
    logic               MultReqD;

    logic [2*NREAD-1:0] ForwardE;
    logic               StallF;
    logic               StallD;
    logic               StallE;
    logic               StallM;
    logic               StallW;
    logic               FlushD;
    logic               FlushE;
    logic               FlushW;
    logic [PW-1:0]      MultPhaseD;
    logic               MultLastD;
    logic [3:0]         StallCause;

    modport master (
        output Match_E_M, Match_E_W, Match_D_E, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, PCWrPendingF, PCSrcW, dstall, istall, uOpStallD, MultReqD,
        input  ForwardE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushW,
               MultPhaseD, MultLastD, StallCause
    );

    modport slave (
        input  Match_E_M, Match_E_W, Match_D_E, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, PCWrPendingF, PCSrcW, dstall, istall, uOpStallD, MultReqD,
        output ForwardE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushW,
               MultPhaseD, MultLastD, StallCause
    );
endinterface

// File: rtl/hazard_unit_param.sv
// Parametrised hazard/forwarding controller for the F/D/E/M/W pipeline: per-port forwarding,
// multi-cycle load-use stalls, an N-phase multi-cycle op sequencer and a registered stall cause.
module hazard_unit_param #(
    parameter int unsigned NREAD           = 2,
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned MULT_PHASES     = 2,
    parameter int unsigned PW              = $clog2(MULT_PHASES)
) (
    input  logic clk,
    input  logic reset,
    hazard_unit_param_if.slave hz
);
    localparam int unsigned LDR_W = 2;
    localparam logic [LDR_W-1:0] LDR_LOAD = LDR_W'(LOAD_USE_CYCLES - 1);
    localparam logic [PW-1:0]    PH_LAST  = PW'(MULT_PHASES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } multState_t;

    multState_t         state;
    multState_t         stateNext;
    logic [PW-1:0]      ph;
    logic [PW-1:0]      phNext;
    logic [LDR_W-1:0]   ldrCnt;
    logic [3:0]         causeQ;
    logic [2*NREAD-1:0] fwd;

    logic memStall;
    logic ldrHit;
    logic ldrStall;
    logic multLast;
    logic multStall;
    logic stallD;
    logic flushD;
    logic flushE;
    logic advance;

    // Per-port forward select; the younger M-stage result wins over W.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            if (hz.Match_E_M[i] && hz.RegWriteM) begin
                fwd[2*i +: 2] = 2'b10;
            end else if (hz.Match_E_W[i] && hz.RegWriteW) begin
                fwd[2*i +: 2] = 2'b01;
            end
        end
    end

    assign memStall = hz.dstall | hz.istall;
    assign ldrHit   = hz.Match_D_E & hz.MemtoRegE;
    assign ldrStall = ((ldrCnt == '0) & ldrHit) | (ldrCnt != '0);
    assign advance  = ~memStall & ~ldrStall;

    // Extra load-use bubbles beyond the first; frozen while memory stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            ldrCnt <= '0;
        end else if (!memStall) begin
            if (ldrCnt == '0) begin
                if (ldrHit) begin
                    ldrCnt <= LDR_LOAD;
                end
            end else begin
                ldrCnt <= ldrCnt - LDR_W'(1);
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ph    <= '0;
        end else begin
            state <= stateNext;
            ph    <= phNext;
        end
    end

    // Sequencer next state; a flush aborts the op before any advance is considered.
    always_comb begin
        stateNext = state;
        phNext    = ph;
        case (state)
            IDLE: begin
                if (hz.MultReqD && advance) begin
                    stateNext = BUSY;
                    phNext    = PW'(1);
                end
            end
            BUSY: begin
                if (flushD || flushE) begin
                    stateNext = IDLE;
                    phNext    = '0;
                end else if (advance) begin
                    if (ph == PH_LAST) begin
                        stateNext = IDLE;
                        phNext    = '0;
                    end else begin
                        phNext = ph + PW'(1);
                    end
                end
            end
        endcase
    end

    // Sequencer outputs.
    always_comb begin
        multLast  = hz.MultReqD & (ph == PH_LAST);
        multStall = hz.MultReqD & ~multLast;
    end

    assign stallD = ldrStall | memStall | hz.uOpStallD | multStall;
    assign flushD = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE | hz.istall;
    assign flushE = ldrStall | hz.BranchTakenE;

    always_ff @(posedge clk) begin
        if (reset) begin
            causeQ <= '0;
        end else begin
            causeQ <= {multStall, hz.uOpStallD, ldrStall, memStall};
        end
    end

    assign hz.ForwardE   = fwd;
    assign hz.StallD     = stallD;
    assign hz.StallF     = stallD | hz.PCWrPendingF;
    assign hz.StallE     = memStall;
    assign hz.StallM     = memStall;
    assign hz.StallW     = hz.istall;
    assign hz.FlushD     = flushD;
    assign hz.FlushE     = flushE;
    assign hz.FlushW     = memStall;
    assign hz.MultPhaseD = ph;
    assign hz.MultLastD  = multLast;
    assign hz.StallCause = causeQ;
endmodule

// File: tb/tb_hazard_unit_param.sv
// Scoreboard bench for hazard_unit_param (NREAD=2, LOAD_USE_CYCLES=3, MULT_PHASES=4):
// a driver pushes reference-model expectations, a monitor pops and compares each cycle.
module tb_hazard_unit_param;
    localparam int NR  = 2;
    localparam int LUC = 3;
    localparam int MP  = 4;
    localparam int PWB = 2;

    typedef struct {
        logic       rst;
        logic [1:0] mEM;
        logic [1:0] mEW;
        logic       mDE, rwM, rwW, ldE, br, pcPend, pcSrc, ds, is, uop, mreq;
    } stim_t;

    typedef struct {
        int         cyc;
        logic [3:0] fwd;
        logic       sF, sD, sE, sM, sW, fD, fE, fW;
        logic [1:0] ph;
        logic       last;
        logic [3:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    hazard_unit_param_if #(.NREAD(NR), .PW(PWB)) hz();

    hazard_unit_param #(
        .NREAD(NR), .LOAD_USE_CYCLES(LUC), .MULT_PHASES(MP), .PW(PWB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   assertions = 0;
    int   failures   = 0;
    bit   done       = 1'b0;

    // Reference state: remaining extra load bubbles, current op phase (0 = idle), cause register.
    int         mLdr   = 0;
    int         mPh    = 0;
    logic [3:0] mCause = 4'b0;
    int         cyc    = 0;

    function automatic stim_t idleStim();
        stim_t s;
        s = '{rst: 1'b0, mEM: 2'b00, mEW: 2'b00, default: 1'b0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   memStall, ldrStall, last, multStall, stallD, flushD, flushE;
        @(posedge clk);
        #1;
        reset           = s.rst;
        hz.Match_E_M    = s.mEM;
        hz.Match_E_W    = s.mEW;
        hz.Match_D_E    = s.mDE;
        hz.RegWriteM    = s.rwM;
        hz.RegWriteW    = s.rwW;
        hz.MemtoRegE    = s.ldE;
        hz.BranchTakenE = s.br;
        hz.PCWrPendingF = s.pcPend;
        hz.PCSrcW       = s.pcSrc;
        hz.dstall       = s.ds;
        hz.istall       = s.is;
        hz.uOpStallD    = s.uop;
        hz.MultReqD     = s.mreq;

        memStall  = s.ds || s.is;
        ldrStall  = (mLdr != 0) || (s.mDE && s.ldE);
        last      = s.mreq && (mPh == MP - 1);
        multStall = s.mreq && !last;
        stallD    = ldrStall || memStall || s.uop || multStall;
        flushD    = s.pcPend || s.pcSrc || s.br || s.is;
        flushE    = ldrStall || s.br;

        e.cyc = cyc;
        e.fwd = 4'b0;
        for (int i = 0; i < NR; i++) begin
            if (s.mEM[i] && s.rwM)      e.fwd[2*i +: 2] = 2'b10;
            else if (s.mEW[i] && s.rwW) e.fwd[2*i +: 2] = 2'b01;
        end
        e.sD = stallD;
        e.sF = stallD || s.pcPend;
        e.sE = memStall;
        e.sM = memStall;
        e.sW = s.is;
        e.fD = flushD;
        e.fE = flushE;
        e.fW = memStall;
        e.ph = 2'(mPh);
        e.last = last;
        e.cause = mCause;
        q.push_back(e);

        if (s.rst) begin
            mLdr = 0; mPh = 0; mCause = 4'b0;
        end else begin
            mCause = {multStall, s.uop, ldrStall, memStall};
            if (!memStall) begin
                if (mLdr > 0) mLdr = mLdr - 1;
                else if (s.mDE && s.ldE) mLdr = LUC - 1;
            end
            if (mPh != 0) begin
                if (flushD || flushE)          mPh = 0;
                else if (!memStall && !ldrStall) mPh = (mPh + 1) % MP;
            end else if (s.mreq && !memStall && !ldrStall) begin
                mPh = 1;
            end
        end
        cyc++;
    endtask

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        stim_t s;
        s = idleStim();
        s.rst = 1'b1;
        reset = 1'b1;
        hz.Match_E_M = '0; hz.Match_E_W = '0; hz.Match_D_E = 0; hz.RegWriteM = 0;
        hz.RegWriteW = 0; hz.MemtoRegE = 0; hz.BranchTakenE = 0; hz.PCWrPendingF = 0;
        hz.PCSrcW = 0; hz.dstall = 0; hz.istall = 0; hz.uOpStallD = 0; hz.MultReqD = 0;
        repeat (2) @(posedge clk);
        step(s);

        s = idleStim(); s.mEM = 2'b01; s.mEW = 2'b11; s.rwM = 1; s.rwW = 1;
        step(s);
        s.rwM = 0;
        step(s);

        s = idleStim(); s.mDE = 1; s.ldE = 1;
        step(s);
        repeat (4) step(idleStim());
        step(s);
        s = idleStim(); s.ds = 1;
        step(s);
        repeat (4) step(idleStim());

        s = idleStim(); s.mreq = 1;
        repeat (4) step(s);
        repeat (2) step(idleStim());

        s = idleStim(); s.mreq = 1;
        repeat (2) step(s);
        s.br = 1;
        step(s);
        repeat (2) step(idleStim());

        s = idleStim(); s.mDE = 1; s.ldE = 1;
        step(s);
        s = idleStim(); s.is = 1; s.pcSrc = 1;
        step(s);
        repeat (3) step(idleStim());

        s = idleStim(); s.mreq = 1;
        repeat (2) step(s);
        s.rst = 1;
        step(s);
        s.rst = 0;
        repeat (4) step(s);
        step(idleStim());

        for (int n = 0; n < 3000; n++) begin
            s.rst    = ($urandom_range(0, 99) < 1);
            s.mEM    = 2'($urandom_range(0, 3));
            s.mEW    = 2'($urandom_range(0, 3));
            s.rwM    = 1'($urandom_range(0, 1));
            s.rwW    = 1'($urandom_range(0, 1));
            s.mDE    = ($urandom_range(0, 99) < 20);
            s.ldE    = ($urandom_range(0, 99) < 40);
            s.br     = ($urandom_range(0, 99) < 8);
            s.pcPend = ($urandom_range(0, 99) < 8);
            s.pcSrc  = ($urandom_range(0, 99) < 5);
            s.ds     = ($urandom_range(0, 99) < 8);
            s.is     = ($urandom_range(0, 99) < 5);
            s.uop    = ($urandom_range(0, 99) < 10);
            s.mreq   = ($urandom_range(0, 99) < 60);
            step(s);
        end
        done = 1'b1;
    end

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        int guard = 0;
        while (!(done && q.size() == 0)) begin
            @(negedge clk);
            guard++;
            if (guard > 50000) begin
                failures++;
                $display("FAIL timeout: queue depth %0d done %0d", q.size(), done);
                break;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ForwardE",   e.cyc, 8'(hz.ForwardE),   8'(e.fwd));
                check("StallF",     e.cyc, 8'(hz.StallF),     8'(e.sF));
                check("StallD",     e.cyc, 8'(hz.StallD),     8'(e.sD));
                check("StallE",     e.cyc, 8'(hz.StallE),     8'(e.sE));
                check("StallM",     e.cyc, 8'(hz.StallM),     8'(e.sM));
                check("StallW",     e.cyc, 8'(hz.StallW),     8'(e.sW));
                check("FlushD",     e.cyc, 8'(hz.FlushD),     8'(e.fD));
                check("FlushE",     e.cyc, 8'(hz.FlushE),     8'(e.fE));
                check("FlushW",     e.cyc, 8'(hz.FlushW),     8'(e.fW));
                check("MultPhaseD", e.cyc, 8'(hz.MultPhaseD), 8'(e.ph));
                check("MultLastD",  e.cyc, 8'(hz.MultLastD),  8'(e.last));
                check("StallCause", e.cyc, 8'(hz.StallCause), 8'(e.cause));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
